// File: rtl/serializador_tx.sv
// rtl/serializador_tx.sv - byte FIFO feeding an MSB-first serializer with a COM alignment burst
module serializador_tx #(
  parameter logic [7:0] COM_BYTE   = 8'hBC,
  parameter int         SYNC_COUNT = 4,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active,
  output logic       tx_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SYNC_COUNT + 1);

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [CW-1:0] com_cnt;
  logic [0:0]    state;

  logic boundary;
  logic run_decide;
  logic push;
  logic pop;

  // The last bit of every byte is the slot where the next byte is chosen.
  assign boundary   = (bit_cnt == 3'd7);
  // RUN load rules apply in RUN and also at the boundary that closes the final sync COM.
  assign run_decide = (state == ST_RUN) || (com_cnt == CW'(SYNC_COUNT - 1));
  assign pop        = boundary && run_decide && (count != '0);
  assign push       = valid_in && ready_out && !reset;

  assign ready_out = (count != (AW + 1)'(FIFO_DEPTH));
  assign data_out  = shreg[7];
  assign active    = (state == ST_RUN);

  // FIFO storage; contents are don't-care once the pointers are flushed.
  always_ff @(posedge clk_32f) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Shifter, bit counter, sync counter and phase; every byte boundary reloads shreg.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      shreg   <= COM_BYTE;
      bit_cnt <= 3'd0;
      com_cnt <= '0;
      state   <= ST_SYNC;
      tx_data <= 1'b0;
    end else if (boundary) begin
      bit_cnt <= 3'd0;
      if (state == ST_SYNC) begin
        com_cnt <= com_cnt + CW'(1);
      end
      if (run_decide) begin
        state <= ST_RUN;
      end
      if (pop) begin
        shreg   <= mem[rd_ptr];
        tx_data <= 1'b1;
      end else begin
        shreg   <= COM_BYTE;
        tx_data <= 1'b0;
      end
    end else begin
      shreg   <= {shreg[6:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_serializador_tx.sv
// tb/tb_serializador_tx.sv - randomized bench for serializador_tx against a byte-slot reference model
module tb_serializador_tx;

  localparam logic [7:0] COM   = 8'hBC;
  localparam int         SYNC  = 4;
  localparam int         DEPTH = 4;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       active;
  logic       tx_data;

  serializador_tx #(
    .COM_BYTE  (COM),
    .SYNC_COUNT(SYNC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .data_out (data_out),
    .active   (active),
    .tx_data  (tx_data)
  );

  always #5 clk_32f = ~clk_32f;

  int         vectors = 0;
  int         miscompares = 0;
  int         n = 0;
  logic [7:0] q_data[$];
  int         q_cyc[$];
  logic [7:0] src[$];
  logic [7:0] cur_byte = COM;
  logic       cur_tx = 1'b0;

  task automatic check(input string tag, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (cycle %0d after reset)", tag, got, exp, n);
    end
  endtask

  // One bit-clock cycle, called at the falling edge: check outputs of cycle n, then drive inputs.
  task automatic step(input logic v, input logic [7:0] d, output logic accepted);
    logic exp_ready;
    if (n % 8 == 0) begin
      // A byte is eligible if it was pushed at least two cycles before its slot starts.
      if ((n / 8) >= SYNC && q_data.size() > 0 && q_cyc[0] <= n - 2) begin
        cur_byte = q_data.pop_front();
        void'(q_cyc.pop_front());
        cur_tx = 1'b1;
      end else begin
        cur_byte = COM;
        cur_tx   = 1'b0;
      end
    end
    exp_ready = (q_data.size() < DEPTH);
    check("data_out", data_out, cur_byte[7 - (n % 8)]);
    check("tx_data", tx_data, cur_tx);
    check("active", active, n >= 8 * SYNC);
    check("ready_out", ready_out, exp_ready);
    valid_in = v;
    data_in  = d;
    accepted = v && exp_ready;
    if (accepted) begin
      q_data.push_back(d);
      q_cyc.push_back(n);
    end
    n++;
    @(posedge clk_32f);
    @(negedge clk_32f);
  endtask

  // Upstream source: offers the head of src and holds it until accepted.
  task automatic tick();
    logic acc;
    if (src.size() > 0) begin
      step(1'b1, src[0], acc);
      if (acc) void'(src.pop_front());
    end else begin
      step(1'b0, 8'($urandom), acc);
    end
  endtask

  task automatic do_reset(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      reset    = 1'b1;
      valid_in = 1'b1;
      data_in  = 8'($urandom);
      if (i > 0) begin
        check("rst_data_out", data_out, 1'b1);
        check("rst_active", active, 1'b0);
        check("rst_tx_data", tx_data, 1'b0);
        check("rst_ready_out", ready_out, 1'b1);
      end
      @(posedge clk_32f);
      @(negedge clk_32f);
    end
    reset    = 1'b0;
    valid_in = 1'b0;
    q_data.delete();
    q_cyc.delete();
    src.delete();
    n = 0;
  endtask

  initial begin
    int rate;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    @(negedge clk_32f);

    // Alignment burst with no data
    do_reset(3);
    repeat (48) tick();

    // Byte pushed during SYNC waits for the first RUN slot
    do_reset(2);
    repeat (3) tick();
    src.push_back(8'hA5);
    repeat (45) tick();

    // Back-to-back pushes filling the FIFO; fifth byte held upstream
    do_reset(2);
    while (n < 40) tick();
    for (int i = 1; i <= 5; i++) src.push_back(8'(i));
    repeat (64) tick();

    // Reset in the middle of a data byte with two entries still queued
    do_reset(2);
    while (n < 41) tick();
    src = '{8'h11, 8'h22, 8'h33};
    while (n < 51) tick();
    do_reset(2);
    repeat (48) tick();

    // Data byte equal to COM
    while (n < 60) tick();
    src.push_back(COM);
    repeat (24) tick();

    // Random traffic with varying density and occasional resets
    do_reset(2);
    rate = 3;
    for (int c = 0; c < 1600; c++) begin
      if (c % 200 == 0) rate = $urandom_range(1, 16);
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 3));
      end else if (src.size() == 0 && $urandom_range(1, rate) == 1) begin
        src.push_back(8'($urandom));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
